// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the MEM request stage and its formatter:
//            access-size codes, the request FSM state encoding and the
//            default reset PC.
// Ports    : none (package)
// Revision : 1.0 - initial split-transaction MEM stage
// ============================================================================
package mem_pkg;

  // Access size codes as carried on in_size / data_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Request FSM: one outstanding transaction at most.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] RST_PC_DEFAULT = 32'h1c00_0000;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Purely combinational data formatting for memory accesses.
//            Store side: lane-replicated write data and byte strobes.
//            Load side : byte/half extraction from the read word with sign
//            or zero extension.
// Ports    : st_size, st_lane, st_src   -> st_wdata, st_wstrb
//            ld_size, ld_lane, ld_unsigned, ld_rdata -> ld_data
//            Size code 3 is handled as a word access.
// Revision : 1.0 - initial split-transaction MEM stage
// ============================================================================
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_src,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store formatting: data is replicated to every lane so the strobes alone
  // select which bytes the memory updates.
  always_comb begin
    st_wdata = st_src;
    st_wstrb = 4'b1111;
    case (st_size)
      SZ_B: begin
        st_wdata = {4{st_src[7:0]}};
        st_wstrb = 4'b0001 << st_lane;
      end
      SZ_H: begin
        st_wdata = {2{st_src[15:0]}};
        st_wstrb = 4'b0011 << {st_lane[1], 1'b0};
      end
      default: begin
        st_wdata = st_src;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction: half-word lane only looks at lane[1], so a misaligned
  // half simply reads the containing aligned half.
  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_lane)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_data = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_req_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_stage
// Purpose  : EX->WB memory stage driving a split-transaction data bus
//            (req/addr_ok/data_ok). Non-memory ops pass with latency 1;
//            memory ops hold one outstanding transaction. A flush marks an
//            in-flight transaction as dropped so its response is discarded.
// Ports    : clk, rst (sync, active-high), flush
//            in_valid/in_ready + in_* : payload from EX
//            out_valid/out_ready + out_*: payload to WB
//            data_* : data-SRAM bus (request fields held stable while
//                     data_req is high)
// Config   : MEM_ALE_CHECK_EN - when defined, misaligned half/word accesses
//            bypass the bus and exit with out_ale = 1, out_result = address.
//            When undefined, out_ale is tied to 0.
// Notes    : ADDR_W must not exceed 32 (the address comes from in_result).
// Revision : 1.0 - initial split-transaction MEM stage
// ============================================================================
module mem_req_stage
  import mem_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DEST_W = 5,
  parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(RST_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_result,
  input  logic              in_mem_en,
  input  logic              in_mem_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_wdata,
  input  logic              in_gr_we,
  input  logic [DEST_W-1:0] in_dest,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_result,
  output logic              out_gr_we,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_ale
);

  state_t state, state_next;
  logic   drop, drop_next;

  // Captured request payload, held for the whole transaction.
  logic [ADDR_W-1:0] req_pc;
  logic [31:0]       req_result;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [3:0]        req_wstrb;
  logic [31:0]       req_wdata;
  logic              req_gr_we;
  logic [DEST_W-1:0] req_dest;

  logic        accept;
  logic        ale;
  logic        go_bus;
  logic        load_acc;
  logic        complete;
  logic [1:0]  norm_size;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_data;

  assign in_ready  = ~rst & (state == IDLE) & (~out_valid | out_ready);
  // A flush in the same cycle kills the incoming instruction.
  assign accept    = in_valid & in_ready & ~flush;
  assign norm_size = (in_size == 2'd3) ? SZ_W : in_size;

`ifdef MEM_ALE_CHECK_EN
  assign ale = in_mem_en &
               (((norm_size == SZ_H) & in_result[0]) |
                ((norm_size == SZ_W) & (in_result[1:0] != 2'b00)));
`else
  assign ale = 1'b0;
`endif

  assign go_bus   = accept & in_mem_en & ~ale;
  assign load_acc = accept & ~go_bus;
  // Flush in the response cycle discards the response like a pending drop.
  assign complete = (state == RESP) & data_data_ok & ~drop & ~flush;

  mem_align u_align (
    .st_size     (norm_size),
    .st_lane     (in_result[1:0]),
    .st_src      (in_wdata),
    .st_wdata    (st_wdata),
    .st_wstrb    (st_wstrb),
    .ld_size     (req_size),
    .ld_lane     (req_result[1:0]),
    .ld_unsigned (req_unsigned),
    .ld_rdata    (data_rdata),
    .ld_data     (ld_data)
  );

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      IDLE: begin
        if (go_bus) state_next = REQ;
      end
      REQ: begin
        // The request cannot be withdrawn once raised; remember the kill
        // and swallow the response later.
        if (flush)        drop_next  = 1'b1;
        if (data_addr_ok) state_next = RESP;
      end
      RESP: begin
        if (flush) drop_next = 1'b1;
        if (data_data_ok) begin
          state_next = IDLE;
          drop_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        drop_next  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc       <= '0;
      req_result   <= '0;
      req_we       <= 1'b0;
      req_size     <= 2'd0;
      req_unsigned <= 1'b0;
      req_wstrb    <= 4'd0;
      req_wdata    <= '0;
      req_gr_we    <= 1'b0;
      req_dest     <= '0;
    end else if (go_bus) begin
      req_pc       <= in_pc;
      req_result   <= in_result;
      req_we       <= in_mem_we;
      req_size     <= norm_size;
      req_unsigned <= in_unsigned;
      req_wstrb    <= in_mem_we ? st_wstrb : 4'd0;
      req_wdata    <= st_wdata;
      req_gr_we    <= in_gr_we;
      req_dest     <= in_dest;
    end
  end

  assign data_req   = (state == REQ);
  assign data_wr    = req_we;
  assign data_size  = req_size;
  assign data_wstrb = req_wstrb;
  assign data_addr  = req_result[ADDR_W-1:0];
  assign data_wdata = req_wdata;

  // --------------------------------------------------------------------------
  // Output registers (to WB)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= RST_PC;
      out_result <= '0;
      out_gr_we  <= 1'b0;
      out_dest   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_acc) begin
      out_valid  <= 1'b1;
      out_pc     <= in_pc;
      out_result <= in_result;
      out_gr_we  <= in_gr_we & ~ale;
      out_dest   <= in_dest;
    end else if (complete) begin
      out_valid  <= 1'b1;
      out_pc     <= req_pc;
      out_result <= req_we ? req_result : ld_data;
      out_gr_we  <= req_gr_we & ~req_we;
      out_dest   <= req_dest;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MEM_ALE_CHECK_EN
  logic ale_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ale_q <= 1'b0;
    end else if (flush) begin
      ale_q <= ale_q;
    end else if (load_acc) begin
      ale_q <= ale;
    end else if (complete) begin
      ale_q <= 1'b0;
    end
  end
  assign out_ale = ale_q;
`else
  assign out_ale = 1'b0;
`endif

endmodule : mem_req_stage
`default_nettype wire

// File: doc/mem_req_stage.md
Name: mem_req_stage

Overview:
- Parametrised successor to the single-cycle MEM stage of the in-order LoongArch pipeline.
- Sits between EX and WB. Drives a split-transaction data-SRAM bus (req/addr_ok/data_ok) instead of a fixed-latency SRAM.
- Formats store data and byte strobes for byte, half and word stores, and aligns and extends load data.
- Holds one outstanding transaction and supports pipeline flush, discarding in-flight responses safely.

Parameters:
- ADDR_W, 32, bus address and PC width.
- DEST_W, 5, register-file index width.
- RST_PC, 32'h1c000000, reset value of out_pc.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the current instruction (exception or redirect from WB)
- in_valid  in  1  EX payload valid
- in_ready  out  1  stage can accept
- out_valid  out  1  WB payload valid
- out_ready  in  1  WB can accept
- in_pc  in  ADDR_W  instruction PC
- in_result  in  32  ALU result; also the memory address
- in_mem_en  in  1  memory operation
- in_mem_we  in  1  1 = store, 0 = load
- in_size  in  2  0 = byte, 1 = half, 2 = word (3 is illegal and treated as word)
- in_unsigned  in  1  zero-extend load
- in_wdata  in  32  store source (rkd)
- in_gr_we  in  1  writes the register file
- in_dest  in  DEST_W  destination register
- data_req  out  1  bus request
- data_wr  out  1  write request
- data_size  out  2  transfer size
- data_wstrb  out  4  byte strobes
- data_addr  out  ADDR_W  address
- data_wdata  out  32  lane-replicated write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response or read data valid
- data_rdata  in  32  read data
- out_pc  out  ADDR_W  PC to WB
- out_result  out  32  extended load data or ALU result
- out_gr_we  out  1  register write enable
- out_dest  out  DEST_W  destination register
- out_ale  out  1  misaligned-address exception flag

Behaviour:
- Reset: state = IDLE, drop = 0, out_valid = 0, out_pc = RST_PC; all other outputs = 0.
- Reset mid-transaction also abandons the bus: data_req drops in the next cycle.
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: data_req = 1, bus fields driven from the captured registers.
  - RESP: waiting for data_ok.
- Handshake: in_ready = ~rst & (state == IDLE) & (~out_valid | out_ready). Acceptance = in_valid & in_ready.
- Non-memory instruction on acceptance:
  - Output registers load in the same edge; out_valid = 1 on the next cycle.
  - out_result = in_result. Latency is 1.
- Memory instruction on acceptance:
  - Payload is captured and the FSM moves IDLE -> REQ.
  - data_req is asserted from the next cycle and held, with bus fields stable, until data_addr_ok.
- REQ & addr_ok -> RESP. The same-cycle data_ok is ignored; data_ok counts only in RESP.
- RESP & data_ok -> IDLE:
  - Output registers load; out_valid = 1 on the next cycle.
  - Loads: lane = addr[1:0]. Extract the byte or half and sign- or zero-extend it per in_unsigned.
  - Stores: out_result = in_result, out_gr_we = 0.
- Store formatting:
  - SB: wdata = {4{b}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 4'b0011 << {addr[1],1'b0}.
  - SW: wstrb = 4'b1111.
  - data_wstrb = 0 for loads.
- out_valid holds until out_ready; the output registers are stable while out_valid & ~out_ready.
- Flush:
  - Clears out_valid in the next cycle.
  - In REQ: sets drop. The request stays asserted until addr_ok (bus rule), after which the FSM goes to RESP.
  - In RESP: sets drop.
  - A response with drop = 1 returns the FSM to IDLE, clears drop and produces no output.
  - A flush in the same cycle as in_valid blocks acceptance (the instruction is killed).
  - A flush in IDLE has no effect on the FSM.
- The bus never sees a second request before the outstanding data_ok.

Optional Feature:
- Macro: MEM_ALE_CHECK_EN.
- With the macro, a misaligned access is detected: half with addr[0] = 1, or word with addr[1:0] != 0.
  - No bus request is made.
  - The instruction exits like a non-memory op with latency 1, out_ale = 1, out_gr_we = 0 and out_result = address (BADV).
- Without the macro, out_ale is tied to 0 and the low address bits are used as-is.

Decomposition:
- Shared package mem_pkg holds:
  - Size constants SZ_B, SZ_H, SZ_W.
  - FSM state enum, IDLE/REQ/RESP.
  - Function-free constant RST_PC default.
- One natural sub-module, mem_align: purely combinational store-strobe/data formatting and load extract/extend, reused later by the D-cache.

Test Plan:
- Non-mem op: in_result = 0x1234, out_ready = 1 -> out_valid one cycle later, out_result = 0x1234, no data_req.
- SB: addr 0x1c0000a2, wdata 0x000000ab -> data_wstrb = 4'b0100, data_wdata = 0xabababab, data_req held until addr_ok with 2-cycle delay.
- LH signed: addr 0x...2, rdata 0x8001ffff, data_ok 3 cycles after addr_ok -> out_result = 0xffff8001, out_valid the cycle after data_ok.
- LBU: addr 0x...3, rdata 0xf0000000 -> out_result = 0x000000f0.
- Flush in RESP, then data_ok -> no out_valid. The next load is accepted and returns its own rdata, not the stale one.
- out_ready = 0 for 5 cycles after a load completes -> outputs stable, in_ready = 0; with MEM_ALE_CHECK_EN, LW at 0x...1 -> out_ale = 1, no data_req.
